// File: rtl/core_mem.sv
// core_mem: activation/weight staging memory and partial-sum accumulator.
//
// Purpose
//   - Two activation banks. External loads fill one bank while the array
//     reads the other (compute) bank. bank_swap exchanges the two banks.
//   - One single-ported weight memory. An L0 read has priority over a load.
//   - A psum memory fed from the OFIFO. In overwrite mode it takes one word
//     per cycle. In accumulate mode it takes one word every three cycles
//     (read, then add, then write back) through a small FSM.
//   - A psum readout port that uses the psum array only when the FSM does
//     not need it.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   wr_valid/wr_ready     external load handshake
//   wr_sel/addr/data      load target (0 activation fill bank, 1 weight)
//   bank_swap             pulse that toggles cmp_bank
//   rd_en/rd_sel/rd_addr  L0 read request (0 compute bank, 1 weight)
//   l0_data/l0_valid      L0 read result, one cycle after rd_en
//   ofifo_valid/data/rd   OFIFO head word and pop strobe
//   acc_mode              0 overwrite psum, 1 accumulate into psum
//   ptr_clr               clears the psum write pointer
//   ps_rd_en/addr/ready   psum readout request handshake
//   ps_rd_data/valid      psum readout result, one cycle after acceptance
//   cmp_bank              activation bank currently used for compute
//   busy                  psum FSM is in the middle of an accumulate
//
// Handshake rule for every request/ready pair in this block:
//   A transfer happens on a rising edge where the request and ready are
//   both 1. Ready is combinational and is never 1 while reset is asserted.
//   A request that is not accepted has no effect. The requester may hold
//   the request or drop it.
module core_mem #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int X_DEPTH = 2048,
    parameter int W_DEPTH = 2048,
    parameter int P_DEPTH = 2048,
    parameter int AW      = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_sel,
    input  logic [AW-1:0]          wr_addr,
    input  logic [row*bw-1:0]      wr_data,
    input  logic                   bank_swap,
    input  logic                   rd_en,
    input  logic                   rd_sel,
    input  logic [AW-1:0]          rd_addr,
    output logic [row*bw-1:0]      l0_data,
    output logic                   l0_valid,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_data,
    output logic                   ofifo_rd,
    input  logic                   acc_mode,
    input  logic                   ptr_clr,
    input  logic                   ps_rd_en,
    input  logic [AW-1:0]          ps_rd_addr,
    output logic                   ps_rd_ready,
    output logic [col*psum_bw-1:0] ps_rd_data,
    output logic                   ps_rd_valid,
    output logic                   cmp_bank,
    output logic                   busy
);

    localparam int XW = row * bw;
    localparam int PW = col * psum_bw;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_RD = 2'd1,
        ACC_WR = 2'd2
    } ps_state_t;

    // Storage. Memory contents are never reset.
    logic [XW-1:0] x_mem0 [X_DEPTH];
    logic [XW-1:0] x_mem1 [X_DEPTH];
    logic [XW-1:0] w_mem  [W_DEPTH];
    logic [PW-1:0] p_mem  [P_DEPTH];

    // ------------------------------------------------------------------
    // Load path and activation bank control
    // ------------------------------------------------------------------
    logic wr_fire;

    // The weight memory has one port, so a same-cycle L0 weight read
    // blocks only weight loads. Activation loads go to the fill bank and
    // never collide with a compute-bank read.
    assign wr_ready = reset & ~(wr_sel & rd_en & rd_sel);
    assign wr_fire  = wr_valid & wr_ready;

    // The fill bank is decided by the pre-edge cmp_bank. A load accepted
    // in a bank_swap cycle therefore lands in the old fill bank.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_sel) begin
            if (cmp_bank) x_mem0[wr_addr] <= wr_data;
            else          x_mem1[wr_addr] <= wr_data;
        end
        if (wr_fire && wr_sel) begin
            w_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_bank <= 1'b0;
        end else if (bank_swap) begin
            cmp_bank <= ~cmp_bank;
        end
    end

    // ------------------------------------------------------------------
    // L0 read port: registered, one-cycle latency, data held when idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            l0_valid <= 1'b0;
            l0_data  <= '0;
        end else begin
            l0_valid <= rd_en;
            if (rd_en) begin
                if (rd_sel)        l0_data <= w_mem[rd_addr];
                else if (cmp_bank) l0_data <= x_mem1[rd_addr];
                else               l0_data <= x_mem0[rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Psum FSM
    // ------------------------------------------------------------------
    ps_state_t     state, state_nx;
    logic [AW-1:0] wp;
    logic [PW-1:0] hold;      // OFIFO word captured for accumulation
    logic [PW-1:0] p_q;       // psum word read back for accumulation
    logic [PW-1:0] lane_sum;
    logic [PW-1:0] p_wdata;
    logic          p_we;
    logic          fsm_rd;
    logic          hold_ld;
    logic          wp_inc;
    logic          ps_accept;
    logic [AW-1:0] p_raddr;

    // Each lane wraps independently. No carry crosses a lane boundary.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < col; i++) begin
            lane_sum[i*psum_bw +: psum_bw] =
                hold[i*psum_bw +: psum_bw] + p_q[i*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        state_nx = state;
        ofifo_rd = 1'b0;
        p_we     = 1'b0;
        p_wdata  = ofifo_data;
        fsm_rd   = 1'b0;
        hold_ld  = 1'b0;
        wp_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    if (acc_mode) begin
                        fsm_rd   = 1'b1;
                        hold_ld  = 1'b1;
                        state_nx = ACC_RD;
                    end else begin
                        p_we   = 1'b1;
                        wp_inc = 1'b1;
                    end
                end
            end
            ACC_RD: state_nx = ACC_WR;
            ACC_WR: begin
                p_we     = 1'b1;
                p_wdata  = lane_sum;
                wp_inc   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // While reset is asserted, nothing pops, reads or writes. A word
        // that was in flight is dropped.
        if (!reset) begin
            ofifo_rd = 1'b0;
            p_we     = 1'b0;
            fsm_rd   = 1'b0;
            hold_ld  = 1'b0;
            wp_inc   = 1'b0;
        end
    end

    assign busy = (state == ACC_RD) || (state == ACC_WR);

    // The readout shares the psum array port. The FSM has priority.
    assign ps_rd_ready = reset & ~(p_we | fsm_rd);
    assign ps_accept   = ps_rd_en & ps_rd_ready;
    assign p_raddr     = fsm_rd ? wp : ps_rd_addr;

    always_ff @(posedge clk) begin
        if (p_we) p_mem[wp] <= p_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wp          <= '0;
            hold        <= '0;
            p_q         <= '0;
            ps_rd_valid <= 1'b0;
            ps_rd_data  <= '0;
        end else begin
            state <= state_nx;
            // A same-cycle write has already used the old wp.
            // ptr_clr overrides the increment.
            if (ptr_clr) begin
                wp <= '0;
            end else if (wp_inc) begin
                wp <= (wp == AW'(P_DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            if (hold_ld) hold <= ofifo_data;
            if (fsm_rd)  p_q  <= p_mem[p_raddr];
            ps_rd_valid <= ps_accept;
            if (ps_accept) ps_rd_data <= p_mem[p_raddr];
        end
    end

endmodule

// File: tb/tb_core_mem.sv
module tb_core_mem;

    localparam int XW = 32;
    localparam int PW = 128;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [XW-1:0] wr_data;
    logic          bank_swap;
    logic          rd_en;
    logic          rd_sel;
    logic [AW-1:0] rd_addr;
    logic [XW-1:0] l0_data;
    logic          l0_valid;
    logic          ofifo_valid;
    logic [PW-1:0] ofifo_data;
    logic          ofifo_rd;
    logic          acc_mode;
    logic          ptr_clr;
    logic          ps_rd_en;
    logic [AW-1:0] ps_rd_addr;
    logic          ps_rd_ready;
    logic [PW-1:0] ps_rd_data;
    logic          ps_rd_valid;
    logic          cmp_bank;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    core_mem dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bank_swap   (bank_swap),
        .rd_en       (rd_en),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .l0_data     (l0_data),
        .l0_valid    (l0_valid),
        .ofifo_valid (ofifo_valid),
        .ofifo_data  (ofifo_data),
        .ofifo_rd    (ofifo_rd),
        .acc_mode    (acc_mode),
        .ptr_clr     (ptr_clr),
        .ps_rd_en    (ps_rd_en),
        .ps_rd_addr  (ps_rd_addr),
        .ps_rd_ready (ps_rd_ready),
        .ps_rd_data  (ps_rd_data),
        .ps_rd_valid (ps_rd_valid),
        .cmp_bank    (cmp_bank),
        .busy        (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Helpers
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [AW-1:0] addr, input logic [XW-1:0] data);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_addr  = addr;
        wr_data  = data;
        #1 check("load_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic l0_read(input string tag, input logic sel, input logic [AW-1:0] addr,
                           input logic [XW-1:0] exp);
        rd_en   = 1'b1;
        rd_sel  = sel;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, l0_valid, 1);
        check({tag, "_data"}, l0_data, exp);
    endtask

    task automatic ps_read(input string tag, input logic [AW-1:0] addr, input logic [PW-1:0] exp);
        ps_rd_en   = 1'b1;
        ps_rd_addr = addr;
        #1 check({tag, "_ready"}, ps_rd_ready, 1);
        tick();
        ps_rd_en = 1'b0;
        check({tag, "_valid"}, ps_rd_valid, 1);
        check({tag, "_data"}, ps_rd_data, exp);
    endtask

    // One overwrite-mode word. ofifo_valid is dropped between edges, so
    // back-to-back calls still present a continuous stream.
    task automatic push(input string tag, input logic [PW-1:0] data, input logic clr);
        ofifo_valid = 1'b1;
        acc_mode    = 1'b0;
        ofifo_data  = data;
        ptr_clr     = clr;
        #1 check({tag, "_ofifo_rd"}, ofifo_rd, 1);
        check({tag, "_ps_rd_ready"}, ps_rd_ready, 0);
        check({tag, "_busy"}, busy, 0);
        tick();
        ofifo_valid = 1'b0;
        ptr_clr     = 1'b0;
    endtask

    // Directed vectors
    logic [PW-1:0] d_vec [5];
    localparam logic [PW-1:0] P_WORD = 128'h8000_FFFF_0001_1234_7FFF_0000_FFFE_7FFF;
    localparam logic [PW-1:0] O_WORD = 128'h8000_0001_FFFF_1111_0002_0005_0003_0001;
    localparam logic [PW-1:0] S_WORD = 128'h0000_0000_0000_2345_8001_0005_0001_8000;
    localparam logic [PW-1:0] Q_WORD = 128'hAAAA_0001_BBBB_0002_CCCC_0003_DDDD_0004;
    localparam logic [PW-1:0] R_WORD = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [PW-1:0] T_WORD = 128'h0F0F_0F0F_F0F0_F0F0_0000_1111_2222_3333;
    localparam logic [PW-1:0] U_WORD = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    localparam logic [PW-1:0] V_WORD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [PW-1:0] GARBAGE = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

    initial begin
        d_vec[0] = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        d_vec[1] = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
        d_vec[2] = 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_A5A5_5A5A;
        d_vec[3] = 128'h8000_7FFF_0000_FFFF_0001_FFFE_4000_C000;
        d_vec[4] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

        // Reset, with requests active so the output gating is exercised.
        reset       = 1'b0;
        wr_valid    = 1'b1;
        wr_sel      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        bank_swap   = 1'b0;
        rd_en       = 1'b0;
        rd_sel      = 1'b0;
        rd_addr     = '0;
        ofifo_valid = 1'b1;
        ofifo_data  = '0;
        acc_mode    = 1'b0;
        ptr_clr     = 1'b0;
        ps_rd_en    = 1'b1;
        ps_rd_addr  = '0;
        tick();
        tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_ps_rd_ready", ps_rd_ready, 0);
        check("rst_ofifo_rd", ofifo_rd, 0);
        check("rst_l0_valid", l0_valid, 0);
        check("rst_ps_rd_valid", ps_rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmp_bank", cmp_bank, 0);
        check("rst_l0_data", l0_data, 0);
        check("rst_ps_rd_data", ps_rd_data, 0);
        wr_valid    = 1'b0;
        ofifo_valid = 1'b0;
        ps_rd_en    = 1'b0;
        reset       = 1'b1;
        tick();

        // Activation banks. A load in the swap cycle goes to old fill bank 1.
        bank_swap = 1'b1;
        load(1'b0, 11'd5, 32'h0BAD_BEEF);
        bank_swap = 1'b0;
        check("swap1_cmp_bank", cmp_bank, 1);
        l0_read("act_b1", 1'b0, 11'd5, 32'h0BAD_BEEF);
        load(1'b0, 11'd5, 32'h1234_5678);
        l0_read("act_preswap", 1'b0, 11'd5, 32'h0BAD_BEEF);
        bank_swap = 1'b1;
        tick();
        bank_swap = 1'b0;
        check("swap2_cmp_bank", cmp_bank, 0);
        l0_read("act_postswap", 1'b0, 11'd5, 32'h1234_5678);
        tick();
        check("l0_idle_valid", l0_valid, 0);
        check("l0_idle_hold", l0_data, 32'h1234_5678);

        // Weight memory: a read in the same cycle blocks the load.
        load(1'b1, 11'd3, 32'h1111_2222);
        wr_valid = 1'b1;
        wr_sel   = 1'b1;
        wr_addr  = 11'd7;
        wr_data  = 32'h3333_4444;
        rd_en    = 1'b1;
        rd_sel   = 1'b1;
        rd_addr  = 11'd3;
        #1 check("wcoll_wr_ready", wr_ready, 0);
        wr_sel = 1'b0;
        #1 check("wcoll_act_wr_ready", wr_ready, 1);
        wr_sel = 1'b1;
        tick();
        rd_en = 1'b0;
        check("wcoll_l0_data", l0_data, 32'h1111_2222);
        #1 check("wretry_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        l0_read("w_retry", 1'b1, 11'd7, 32'h3333_4444);

        // Overwrite stream of 4 words into psum[0..3].
        for (int i = 0; i < 4; i++) push("ovw", d_vec[i], 1'b0);
        #1 check("ovw_end_ofifo_rd", ofifo_rd, 0);
        for (int i = 0; i < 4; i++) ps_read("ovw_rd", AW'(i), d_vec[i]);
        // wp must now be 4.
        push("ovw_wp4", d_vec[4], 1'b0);
        ps_read("ovw_wp4_rd", 11'd4, d_vec[4]);

        // Accumulate into psum[0], lane 0 overflowing 0x7FFF -> 0x8000.
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        push("acc_seed", P_WORD, 1'b0);
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        ofifo_valid = 1'b1;
        acc_mode    = 1'b1;
        ofifo_data  = O_WORD;
        #1 check("acc_idle_ofifo_rd", ofifo_rd, 1);
        check("acc_idle_busy", busy, 0);
        tick();
        // Mode and data change while the word is in flight.
        acc_mode   = 1'b0;
        ofifo_data = GARBAGE;
        #1 check("acc_rd_busy", busy, 1);
        check("acc_rd_ofifo_rd", ofifo_rd, 0);
        tick();
        #1 check("acc_wr_busy", busy, 1);
        check("acc_wr_ofifo_rd", ofifo_rd, 0);
        check("acc_wr_ps_rd_ready", ps_rd_ready, 0);
        ofifo_valid = 1'b0;
        tick();
        check("acc_done_busy", busy, 0);
        ps_read("acc_sum", 11'd0, S_WORD);

        // Fill to wp = P_DEPTH-1. wp is 1 here, so 2046 more words are needed.
        ofifo_valid = 1'b1;
        acc_mode    = 1'b0;
        for (int i = 0; i < 2046; i++) begin
            ofifo_data = PW'(i);
            tick();
        end
        ofifo_valid = 1'b0;
        ps_read("fill_1000", 11'd1000, PW'(999));
        push("wrap_last", Q_WORD, 1'b0);
        push("wrap_first", R_WORD, 1'b0);
        ps_read("wrap_2047", 11'd2047, Q_WORD);
        ps_read("wrap_0", 11'd0, R_WORD);
        // ptr_clr in the same cycle as a write at wp=1.
        push("clr_write", T_WORD, 1'b1);
        push("clr_after", U_WORD, 1'b0);
        ps_read("clr_old_wp", 11'd1, T_WORD);
        ps_read("clr_new_wp", 11'd0, U_WORD);

        // Reset during ACC_RD targeting psum[1].
        bank_swap = 1'b1;
        tick();
        bank_swap = 1'b0;
        check("pre_rst_cmp_bank", cmp_bank, 1);
        ofifo_valid = 1'b1;
        acc_mode    = 1'b1;
        ofifo_data  = O_WORD;
        tick();
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1 check("mid_rst_ofifo_rd", ofifo_rd, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_ps_rd_ready", ps_rd_ready, 0);
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmp_bank", cmp_bank, 0);
        check("mid_rst_l0_valid", l0_valid, 0);
        check("mid_rst_l0_data", l0_data, 0);
        check("mid_rst_ps_rd_valid", ps_rd_valid, 0);
        check("mid_rst_ps_rd_data", ps_rd_data, 0);
        ofifo_valid = 1'b0;
        acc_mode    = 1'b0;
        reset       = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        ps_read("post_rst_target", 11'd1, T_WORD);
        l0_read("post_rst_act", 1'b0, 11'd5, 32'h1234_5678);
        push("post_rst_wp0", V_WORD, 1'b0);
        ps_read("post_rst_wp0_rd", 11'd0, V_WORD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem.md
CORE_MEM -- requirements
Module: core_mem

Interface
REQ-001 Parameters SHALL be: bw 4, activation/weight lane width; psum_bw 16, psum lane width; row 8, lanes per x/w word; col 8, lanes per psum word; X_DEPTH 2048, words per activation bank; W_DEPTH 2048, weight words; P_DEPTH 2048, psum words; AW 11, address width, at least clog2 of each depth.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  external load request
- wr_ready  out  1  load accepted this cycle
- wr_sel  in  1  load target: 0 activation fill bank, 1 weight memory
- wr_addr  in  AW  load address
- wr_data  in  row*bw  load data
- bank_swap  in  1  pulse; exchanges activation fill and compute banks
- rd_en  in  1  L0 read request
- rd_sel  in  1  L0 read source: 0 activation compute bank, 1 weight memory
- rd_addr  in  AW  L0 read address
- l0_data  out  row*bw  read data
- l0_valid  out  1  l0_data valid
- ofifo_valid  in  1  OFIFO holds data
- ofifo_data  in  col*psum_bw  OFIFO head word
- ofifo_rd  out  1  OFIFO pop
- acc_mode  in  1  0 overwrite psum, 1 accumulate into psum
- ptr_clr  in  1  clears psum write pointer
- ps_rd_en  in  1  psum readout request
- ps_rd_addr  in  AW  psum readout address
- ps_rd_ready  out  1  readout accepted
- ps_rd_data  out  col*psum_bw  readout data
- ps_rd_valid  out  1  ps_rd_data valid
- cmp_bank  out  1  current activation compute bank index
- busy  out  1  psum FSM not in IDLE

Function
REQ-003 Activation storage SHALL be two banks of X_DEPTH words; loads with wr_sel=0 SHALL write bank ~cmp_bank, L0 reads with rd_sel=0 SHALL read bank cmp_bank.
REQ-004 bank_swap SHALL toggle cmp_bank at the clock edge where it is sampled high; a load accepted in the same cycle SHALL land in the pre-swap fill bank.
REQ-005 Weight memory SHALL be single-ported; with rd_en=1 and rd_sel=1, wr_ready SHALL be 0 for wr_sel=1 (read wins); otherwise wr_ready=1.
REQ-006 L0 read latency SHALL be 1 cycle: l0_valid=1 and l0_data=mem[rd_addr] in the cycle after rd_en; l0_valid=0 otherwise, l0_data holds its last value.
REQ-007 Psum FSM states SHALL be IDLE, ACC_RD, ACC_WR.
REQ-008 IDLE, acc_mode=0, ofifo_valid=1: ofifo_rd=1, psum[wp] <= ofifo_data same edge, wp increments, FSM stays IDLE (1 word/cycle).
REQ-009 IDLE, acc_mode=1, ofifo_valid=1: ofifo_rd=1, ofifo_data captured to hold register, psum[wp] read, next state ACC_RD.
REQ-010 ACC_RD SHALL go unconditionally to ACC_WR, ofifo_rd=0; ACC_WR SHALL write psum[wp] <= per-lane sum of hold and read data, increment wp, and return to IDLE, ofifo_rd=0 (1 word per 3 cycles).
REQ-011 Per-lane add SHALL be signed psum_bw-bit two's complement, modulo 2^psum_bw, no saturation, no carry between lanes.
REQ-012 wp SHALL wrap from P_DEPTH-1 to 0; ptr_clr SHALL set wp to 0 and take priority over any same-cycle increment; the same-cycle write, if any, uses the pre-clear wp.
REQ-013 acc_mode SHALL be sampled only in IDLE; changes during ACC_RD/ACC_WR SHALL not affect the in-flight word.
REQ-014 Psum readout: ps_rd_ready=0 when the psum array is written or read by the FSM this cycle, else 1; accepted reads return ps_rd_data with ps_rd_valid=1 one cycle later.
REQ-015 busy SHALL be 1 exactly when the FSM is in ACC_RD or ACC_WR.

Reset
REQ-016 With reset=0 at a clock edge: FSM to IDLE, wp=0, cmp_bank=0, l0_valid=0, ps_rd_valid=0, ofifo_rd=0, l0_data=0, ps_rd_data=0, hold register=0; memory contents are not cleared.
REQ-017 Reset asserted mid-accumulate SHALL abandon the in-flight word without writing psum.
REQ-018 While reset=0, wr_ready and ps_rd_ready SHALL be 0.

Verification
REQ-019 Load 0x12345678 at activation addr 5, bank_swap, rd_en rd_sel=0 addr 5 -> l0_data=0x12345678, l0_valid=1 one cycle later; before the swap, the same read returns the other bank's value.
REQ-020 Weight load and weight L0 read in the same cycle -> wr_ready=0; write retried next cycle lands.
REQ-021 acc_mode=0, 4 OFIFO words streamed -> ofifo_rd high 4 consecutive cycles, psum[0..3] match inputs, wp=4.
REQ-022 acc_mode=1, psum[0] lane0=0x7FFF, OFIFO lane0=0x0001 -> psum[0] lane0=0x8000 after 3 cycles, busy high 2 cycles, ofifo_rd high 1 cycle.
REQ-023 wp=P_DEPTH-1, one overwrite -> wp=0; ptr_clr with a write in the same cycle -> write at the old wp, wp=0.
REQ-024 reset=0 during ACC_RD -> target psum word unchanged, FSM IDLE, all outputs at REQ-016 values.
